// File: rtl/f_stage_if.sv
// f_stage_if
// Instruction-memory bus between the fetch stage and a synchronous IM.
//   im_addr  : byte address presented this cycle (fetch -> IM)
//   im_rdata : word for the address presented in the previous cycle (IM -> fetch)
// Modports: master = fetch stage, slave = instruction memory.
interface f_stage_if;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;

    modport master (output im_addr, input im_rdata);
    modport slave  (input im_addr, output im_rdata);
endinterface

// File: rtl/f_stage.sv
// f_stage
// MIPS fetch stage. Owns the program counter, drives the synchronous
// instruction memory and presents F_PC / F_I to the IF/ID register.
// Redirects are resolved from the instruction in D using the delay-slot rule.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   WE                 : pipeline enable (0 = stall, F_PC/F_I held)
//   D_Branch           : branch class of the instruction in D
//   D_I, D_PC          : instruction and PC in D
//   D_rs_fw, D_rt_fw   : forwarded GPR[rs], GPR[rt] for the instruction in D
//   im                 : IM bus (master side): im_addr out, im_rdata in
//   F_PC, F_I          : PC and instruction currently in F
//   f_exc, f_exc_pc    : sticky fetch-fault flag and PC of the first fault
//
// Optional feature: define FETCH_RANGE_CHECK_EN to enable the fetch
// alignment/range check. Without it f_exc/f_exc_pc are tied to 0.
module f_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         WE,
    input  logic [3:0]   D_Branch,
    input  logic [31:0]  D_I,
    input  logic [31:0]  D_PC,
    input  logic [31:0]  D_rs_fw,
    input  logic [31:0]  D_rt_fw,
    f_stage_if.master    im,
    output logic [31:0]  F_PC,
    output logic [31:0]  F_I,
    output logic         f_exc,
    output logic [31:0]  f_exc_pc
);

    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BGEZ = 4'd3;
    localparam logic [3:0] BR_BGTZ = 4'd4;
    localparam logic [3:0] BR_BLEZ = 4'd5;
    localparam logic [3:0] BR_BLTZ = 4'd6;
    localparam logic [3:0] BR_JAL  = 4'd7;
    localparam logic [3:0] BR_REG  = 4'd8;

    logic [31:0] d_pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jal_target;
    logic        rs_neg;
    logic        rs_zero;
    logic        taken;
    logic [31:0] npc;
    logic [31:0] next_pc;

    // Opcode bits of D_I are decoded upstream; only imm16/index26 matter here.
    logic unused_d_i;
    assign unused_d_i = ^D_I[31:26];

    assign d_pc_plus4 = D_PC + 32'd4;
    assign br_target  = d_pc_plus4 + {{14{D_I[15]}}, D_I[15:0], 2'b00};
    assign jal_target = {d_pc_plus4[31:28], D_I[25:0], 2'b00};
    assign rs_neg     = D_rs_fw[31];
    assign rs_zero    = (D_rs_fw == 32'd0);

    always_comb begin
        taken = 1'b0;
        npc   = F_PC + 32'd4;
        case (D_Branch)
            BR_BEQ:  taken = (D_rs_fw == D_rt_fw);
            BR_BNE:  taken = (D_rs_fw != D_rt_fw);
            BR_BGEZ: taken = !rs_neg;
            BR_BGTZ: taken = !rs_neg && !rs_zero;
            BR_BLEZ: taken = rs_neg || rs_zero;
            BR_BLTZ: taken = rs_neg;
            BR_JAL:  npc   = jal_target;
            BR_REG:  npc   = D_rs_fw;
            default: taken = 1'b0;   // codes 0 and 9..15: sequential fetch
        endcase
        if (taken) begin
            npc = br_target;
        end
    end

    // im_addr is exactly the value F_PC takes at the next edge, so the
    // registered IM read always lines up with F_PC without a skid buffer.
    always_comb begin
        if (reset) begin
            next_pc = RESET_PC;
        end else if (!WE) begin
            next_pc = F_PC;
        end else begin
            next_pc = npc;
        end
    end

    assign im.im_addr = next_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            F_PC <= RESET_PC;
        end else begin
            F_PC <= next_pc;
        end
    end

`ifdef FETCH_RANGE_CHECK_EN
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

    logic fault;
    assign fault = (F_PC[1:0] != 2'b00) ||
                   (F_PC < IM_BASE) ||
                   ({1'b0, F_PC} >= IM_LIMIT);

    assign F_I = (reset || fault) ? 32'd0 : im.im_rdata;

    // Only the first fault is recorded; later faults leave the capture alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_exc    <= 1'b0;
            f_exc_pc <= 32'd0;
        end else if (fault && WE && !f_exc) begin
            f_exc    <= 1'b1;
            f_exc_pc <= F_PC;
        end
    end
`else
    assign F_I      = reset ? 32'd0 : im.im_rdata;
    assign f_exc    = 1'b0;
    assign f_exc_pc = 32'd0;
`endif

endmodule

// File: tb/tb_f_stage.sv
module tb_f_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [3:0]  D_Branch;
    logic [31:0] D_I;
    logic [31:0] D_PC;
    logic [31:0] D_rs_fw;
    logic [31:0] D_rt_fw;
    logic [31:0] F_PC;
    logic [31:0] F_I;
    logic        f_exc;
    logic [31:0] f_exc_pc;

    int errors = 0;
    int checks = 0;

    f_stage_if imb ();

    f_stage dut (
        .clk      (clk),
        .reset    (reset),
        .WE       (WE),
        .D_Branch (D_Branch),
        .D_I      (D_I),
        .D_PC     (D_PC),
        .D_rs_fw  (D_rs_fw),
        .D_rt_fw  (D_rt_fw),
        .im       (imb.master),
        .F_PC     (F_PC),
        .F_I      (F_I),
        .f_exc    (f_exc),
        .f_exc_pc (f_exc_pc)
    );

    always #5 clk = ~clk;

    // IM model: word at 0x3000 + 4*i holds 0xA000_0000 + i; outside the IM
    // it returns a recognisable junk word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h3000 && a < 32'h7000)
            return 32'hA000_0000 + ((a - 32'h3000) >> 2);
        return 32'hDEAD_BEEF;
    endfunction

    always_ff @(posedge clk) imb.im_rdata <= mem_word(imb.im_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] br, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt);
        D_Branch = br;
        D_PC     = pc;
        D_I      = ins;
        D_rs_fw  = rs;
        D_rt_fw  = rt;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        WE    = 1'b1;
        set_d(4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        checks++; if (F_PC !== 32'h3000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", F_PC, 32'h3000); end
        checks++; if (F_I !== 32'h0) begin errors++; $display("FAIL reset_fi got=%h exp=%h", F_I, 32'h0); end
        checks++; if (f_exc !== 1'b0) begin errors++; $display("FAIL reset_exc got=%b exp=0", f_exc); end
        checks++; if (f_exc_pc !== 32'h0) begin errors++; $display("FAIL reset_exc_pc got=%h exp=0", f_exc_pc); end
        reset = 1'b0;
        #1;
        checks++; if (F_I !== 32'hA000_0000) begin errors++; $display("FAIL first_fetch got=%h exp=%h", F_I, 32'hA000_0000); end
    endtask

    task automatic test_free_run();
        step();
        checks++; if (F_PC !== 32'h3004 || F_I !== 32'hA000_0001) begin errors++; $display("FAIL run1 pc=%h fi=%h exp pc=3004 fi=a0000001", F_PC, F_I); end
        step();
        checks++; if (F_PC !== 32'h3008 || F_I !== 32'hA000_0002) begin errors++; $display("FAIL run2 pc=%h fi=%h exp pc=3008 fi=a0000002", F_PC, F_I); end
    endtask

    task automatic test_beq();
        set_d(4'd1, 32'h3004, 32'h0000_FFFE, 32'd5, 32'd5);
        step();
        checks++; if (F_PC !== 32'h3000 || F_I !== 32'hA000_0000) begin errors++; $display("FAIL beq_taken pc=%h fi=%h exp pc=3000 fi=a0000000", F_PC, F_I); end
        set_d(4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        set_d(4'd1, 32'h3004, 32'h0000_FFFE, 32'd5, 32'd6);
        step();
        checks++; if (F_PC !== 32'h300C || F_I !== 32'hA000_0003) begin errors++; $display("FAIL beq_not_taken pc=%h fi=%h exp pc=300c fi=a0000003", F_PC, F_I); end
    endtask

    task automatic test_cond_branches();
        set_d(4'd6, 32'h3008, 32'h0000_0004, 32'h8000_0000, 32'h0);   // BLTZ taken
        step();
        checks++; if (F_PC !== 32'h301C || F_I !== 32'hA000_0007) begin errors++; $display("FAIL bltz pc=%h fi=%h exp pc=301c fi=a0000007", F_PC, F_I); end
        set_d(4'd4, 32'h3018, 32'h0000_0010, 32'h0, 32'h0);           // BGTZ rs=0 not taken
        step();
        checks++; if (F_PC !== 32'h3020 || F_I !== 32'hA000_0008) begin errors++; $display("FAIL bgtz pc=%h fi=%h exp pc=3020 fi=a0000008", F_PC, F_I); end
        set_d(4'd5, 32'h3020, 32'h0000_FFFC, 32'h0, 32'h0);           // BLEZ rs=0 taken
        step();
        checks++; if (F_PC !== 32'h3014 || F_I !== 32'hA000_0005) begin errors++; $display("FAIL blez pc=%h fi=%h exp pc=3014 fi=a0000005", F_PC, F_I); end
        set_d(4'd9, 32'h3010, 32'h0000_0040, 32'h0, 32'h0);           // undefined code
        step();
        checks++; if (F_PC !== 32'h3018) begin errors++; $display("FAIL undef_code pc=%h exp=3018", F_PC); end
        set_d(4'd3, 32'h3018, 32'h0000_0002, 32'h0, 32'h0);           // BGEZ rs=0 taken
        step();
        checks++; if (F_PC !== 32'h3024 || F_I !== 32'hA000_0009) begin errors++; $display("FAIL bgez pc=%h fi=%h exp pc=3024 fi=a0000009", F_PC, F_I); end
        set_d(4'd2, 32'h3020, 32'h0000_0010, 32'd7, 32'd7);           // BNE equal not taken
        step();
        checks++; if (F_PC !== 32'h3028) begin errors++; $display("FAIL bne_nt pc=%h exp=3028", F_PC); end
    endtask

    task automatic test_jumps();
        set_d(4'd7, 32'h3010, 32'h0000_0C40, 32'h0, 32'h0);
        step();
        checks++; if (F_PC !== 32'h3100 || F_I !== 32'hA000_0040) begin errors++; $display("FAIL jal pc=%h fi=%h exp pc=3100 fi=a0000040", F_PC, F_I); end
        set_d(4'd8, 32'h3100, 32'h0, 32'h3020, 32'h0);
        step();
        checks++; if (F_PC !== 32'h3020 || F_I !== 32'hA000_0008) begin errors++; $display("FAIL jr pc=%h fi=%h exp pc=3020 fi=a0000008", F_PC, F_I); end
    endtask

    task automatic test_stall();
        WE = 1'b0;
        set_d(4'd2, 32'h3020, 32'h0000_0008, 32'd1, 32'd2);           // BNE taken -> 0x3044
        #1;
        checks++; if (imb.im_addr !== 32'h3020) begin errors++; $display("FAIL stall_addr got=%h exp=3020", imb.im_addr); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (F_PC !== 32'h3020 || F_I !== 32'hA000_0008) begin errors++; $display("FAIL stall_hold%0d pc=%h fi=%h exp pc=3020 fi=a0000008", i, F_PC, F_I); end
        end
        WE = 1'b1;
        step();
        checks++; if (F_PC !== 32'h3044 || F_I !== 32'hA000_0011) begin errors++; $display("FAIL stall_release pc=%h fi=%h exp pc=3044 fi=a0000011", F_PC, F_I); end
        WE = 1'b0;
        step();
        reset = 1'b1;
        step();
        checks++; if (F_PC !== 32'h3000 || F_I !== 32'h0) begin errors++; $display("FAIL stall_reset pc=%h fi=%h exp pc=3000 fi=0", F_PC, F_I); end
        reset = 1'b0;
        WE    = 1'b1;
        set_d(4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        checks++; if (F_I !== 32'hA000_0000) begin errors++; $display("FAIL post_reset_fi got=%h exp=a0000000", F_I); end
    endtask

    task automatic test_range_check();
        logic [31:0] exp_fi;
        logic        exp_exc;
        logic [31:0] exp_epc;
`ifdef FETCH_RANGE_CHECK_EN
        exp_fi  = 32'h0;
        exp_exc = 1'b1;
        exp_epc = 32'h7000;
`else
        exp_fi  = 32'hDEAD_BEEF;
        exp_exc = 1'b0;
        exp_epc = 32'h0;
`endif
        set_d(4'd8, 32'h3000, 32'h0, 32'h7000, 32'h0);
        step();
        checks++; if (F_PC !== 32'h7000 || F_I !== exp_fi) begin errors++; $display("FAIL range_fi pc=%h fi=%h exp pc=7000 fi=%h", F_PC, F_I, exp_fi); end
        checks++; if (f_exc !== 1'b0) begin errors++; $display("FAIL range_exc_early got=%b exp=0", f_exc); end
        set_d(4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        checks++; if (F_PC !== 32'h7004 || F_I !== exp_fi) begin errors++; $display("FAIL range_advance pc=%h fi=%h exp pc=7004 fi=%h", F_PC, F_I, exp_fi); end
        checks++; if (f_exc !== exp_exc || f_exc_pc !== exp_epc) begin errors++; $display("FAIL range_exc exc=%b epc=%h exp exc=%b epc=%h", f_exc, f_exc_pc, exp_exc, exp_epc); end
        step();
        checks++; if (f_exc !== exp_exc || f_exc_pc !== exp_epc) begin errors++; $display("FAIL range_sticky exc=%b epc=%h exp exc=%b epc=%h", f_exc, f_exc_pc, exp_exc, exp_epc); end
        reset = 1'b1;
        step();
        checks++; if (f_exc !== 1'b0 || f_exc_pc !== 32'h0) begin errors++; $display("FAIL range_reset exc=%b epc=%h exp exc=0 epc=0", f_exc, f_exc_pc); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_beq();
        test_cond_branches();
        test_jumps();
        test_stall();
        test_range_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/f_stage.md
# f_stage

Fetch stage of the five-stage MIPS pipeline: owns the program counter, drives the synchronous instruction memory, and presents `F_I`/`F_PC` to the IF/ID register. It is the producer end of the IF/ID interface and the consumer of the `D_Branch` code that the decode stage derives from `D_I`. All redirects resolve in D and use the delay-slot rule: the instruction already in F (the delay slot) always completes, and the redirect takes effect on the following fetch.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value after reset
- `IM_BASE`, 32'h0000_3000, lowest legal fetch address
- `IM_WORDS`, 4096, instruction memory depth in words
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `WE`  in  1  pipeline enable from the hazard unit; 0 = stall (same signal as the IF/ID write enable)
- `D_Branch`  in  4  branch class of the instruction in D, using the `define.v` codes: 0 none, `BEQ`=1, `BNE`=2, `BGEZ`=3, `BGTZ`=4, `BLEZ`=5, `BLTZ`=6, `JAL`=7 (j/jal), `REG`=8 (jr/jalr)
- `D_I`  in  32  instruction in D (imm16 / index26 source)
- `D_PC`  in  32  PC of the instruction in D
- `D_rs_fw`, `D_rt_fw`  in  32 each  forwarded GPR[rs], GPR[rt] for the instruction in D
- `im_addr`  out  32  byte address to the IM; registered read, data returned next cycle
- `im_rdata`  in  32  IM read data for the address presented in the previous cycle
- `F_PC`  out  32  PC of the instruction currently in F
- `F_I`  out  32  instruction currently in F
- `f_exc`  out  1  sticky fetch-fault flag (see Configuration)
- `f_exc_pc`  out  32  PC of the first faulting fetch

## Operation
- `F_PC` is a register. `im_addr` is the value `F_PC` takes at the next edge, so `im_rdata` always matches the current `F_PC` and no skid buffer is needed.
- `im_addr` selection, in priority order:
  - `reset`: `RESET_PC`
  - `!WE`: `F_PC` (re-read)
  - otherwise: `NPC`
- `NPC` selection:
  - Conditional branch taken: `D_PC + 4 + (sext(D_I[15:0]) << 2)`
  - `JAL`: `{(D_PC+4)[31:28], D_I[25:0], 2'b00}`
  - `REG`: `D_rs_fw`
  - Otherwise: `F_PC + 4`
- Branch conditions. All comparisons against zero are signed 32-bit.
  - `BEQ`: rs==rt
  - `BNE`: rs!=rt
  - `BGEZ`: rs>=0
  - `BGTZ`: rs>0
  - `BLEZ`: rs<=0
  - `BLTZ`: rs<0
  - Not taken: `F_PC+4`
- Undefined `D_Branch` codes (9–15) are treated as 0.
- Adders wrap modulo 2^32. `REG` targets are used unmodified, so misalignment is caught only by the range check.
- `F_I = im_rdata`, except it is forced to 0 (nop) during `reset` and on a faulting fetch when the check is enabled.

## Timing
- Reset values:
  - `F_PC` = `RESET_PC`
  - `F_I` = 0
  - `f_exc` = 0
  - `f_exc_pc` = 0
- In the first cycle after reset deasserts, `F_PC`=0x3000 and `F_I`=mem[0x3000]. Fetch latency is 1 cycle.
- Redirect latency: a branch in D at cycle t with `WE`=1 makes `F_PC`=target at t+1. The delay slot was in F at cycle t.
- Stall: while `WE`=0, `F_PC` and `F_I` are held and any branch decision in D is discarded. D re-evaluates the branch after the stall because IF/ID is also frozen.
- Reset mid-stall or mid-redirect: reset wins and all state returns to reset values at the next edge.
- No internal combinational path from `F_*` to `WE`. The `D_*` to `im_addr` path is combinational.

## Configuration
- `FETCH_RANGE_CHECK_EN` defined:
  - A fetch is faulting if `F_PC[1:0]!=0` or `F_PC` lies outside [`IM_BASE`, `IM_BASE+4*IM_WORDS`).
  - A faulting fetch drives `F_I`=0.
  - On the first faulting cycle with `WE`=1, `f_exc` sets to 1 and `f_exc_pc` captures `F_PC`. Both then hold until reset.
  - `F_PC` still advances normally, so the pipeline drains nops.
- `FETCH_RANGE_CHECK_EN` undefined:
  - `F_I = im_rdata` unconditionally.
  - `f_exc` and `f_exc_pc` are tied to 0 and no check logic is instantiated.

## Test plan
- Reset then free-run, `D_Branch`=0: `F_PC` = 0x3000, 0x3004, 0x3008; `F_I` equals mem words 0, 1, 2 in order.
- `D_PC`=0x3004, `D_Branch`=`BEQ`, `D_I[15:0]`=0xFFFE, rs=rt=5, `F_PC`=0x3008 → next `F_PC`=0x3000. Repeat with rt=6 → next `F_PC`=0x300C.
- `BLTZ` with rs=0x8000_0000 → taken. `BGTZ` with rs=0 → not taken. `BLEZ` with rs=0 → taken.
- `D_PC`=0x3010, `D_Branch`=`JAL`, `D_I[25:0]`=0x0000C40 → `F_PC`=0x0000_3100. `REG` with `D_rs_fw`=0x3020 → `F_PC`=0x3020.
- `WE`=0 for 3 cycles with a taken `BNE` in D → `F_PC` and `F_I` unchanged for those 3 cycles. On `WE`=1, redirect happens the next cycle. Reset asserted during the stall → `F_PC`=0x3000.
- With `FETCH_RANGE_CHECK_EN`: `REG` to 0x7000 → `F_I`=0, `f_exc`=1, `f_exc_pc`=0x7000. A later fault at 0x7004 leaves `f_exc_pc`=0x7000. Without the macro, `f_exc` stays 0.
